// File: rtl/leve_pkg.sv
// Shared types and constants for the LEVE operand-fetch / register-file slice.
package leve_pkg;

    localparam int REG_AW = 5;
    localparam int NREG   = 32;

    typedef logic [REG_AW-1:0] reg_idx_t;

    // One in-flight instruction as tracked between issue and writeback
    typedef struct packed {
        logic     vld;
        logic     wen;
        reg_idx_t rd;
    } pend_slot_t;

    // True when the slot will (or does) produce a value for register idx
    function automatic logic slot_targets(input pend_slot_t slot, input reg_idx_t idx);
        return slot.vld & slot.wen & (slot.rd == idx);
    endfunction

endpackage

// File: rtl/leve_regfile.sv
// Integer register file: NREG x XLEN, two combinational read ports, a debug
// read port and one write port. x0 is never written and always reads zero.
module leve_regfile
    import leve_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic            i_we,
    input  logic [REG_AW-1:0] i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [REG_AW-1:0] i_raddr1,
    input  logic [REG_AW-1:0] i_raddr2,
    input  logic [REG_AW-1:0] i_dbg_raddr,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2,
    output logic [XLEN-1:0] o_dbg_rdata
);

    logic [XLEN-1:0] r_regs [NREG];

    // Storage update: whole array cleared on reset, writes to x0 are dropped
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read ports: plain array contents, x0 forced to zero
    always_comb begin
        o_rdata1    = (i_raddr1    == '0) ? '0 : r_regs[i_raddr1];
        o_rdata2    = (i_raddr2    == '0) ? '0 : r_regs[i_raddr2];
        o_dbg_rdata = (i_dbg_raddr == '0) ? '0 : r_regs[i_dbg_raddr];
    end

endmodule

// File: rtl/leve_operand_fetch.sv
// Operand-fetch stage of the LEVE core: accepts decoded instructions, resolves
// operands from the register file or the ALU result bypass, stalls on a
// dependency against the op currently in the ALU, and retires ALU results.
module leve_operand_fetch
    import leve_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              ID_VALID,
    output logic              ID_READY,
    input  logic [REG_AW-1:0] ID_RS1,
    input  logic [REG_AW-1:0] ID_RS2,
    input  logic [REG_AW-1:0] ID_RD,
    input  logic              ID_WEN,
    output logic              RS_D_VALID,
    output logic [XLEN-1:0]   RS1_D,
    output logic [XLEN-1:0]   RS2_D,
    input  logic              RD_WE,
    input  logic [XLEN-1:0]   RD_D,
    input  logic [REG_AW-1:0] DBG_RADDR,
    output logic [XLEN-1:0]   DBG_RDATA,
    output logic              ERR
);

    pend_slot_t      r_s1;
    pend_slot_t      r_s2;
    logic            r_rsValid;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic            r_err;

    logic            w_accept;
    logic            w_hazard;
    logic            w_wbEn;
    logic            w_s2Fwd;
    logic [XLEN-1:0] w_arr1;
    logic [XLEN-1:0] w_arr2;
    logic [XLEN-1:0] w_rs1Val;
    logic [XLEN-1:0] w_rs2Val;

    leve_regfile #(.XLEN(XLEN)) u_regfile (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .i_we        (w_wbEn),
        .i_waddr     (r_s2.rd),
        .i_wdata     (RD_D),
        .i_raddr1    (ID_RS1),
        .i_raddr2    (ID_RS2),
        .i_dbg_raddr (DBG_RADDR),
        .o_rdata1    (w_arr1),
        .o_rdata2    (w_arr2),
        .o_dbg_rdata (DBG_RDATA)
    );

    // Hazard, handshake and writeback enables; the ALU op's result is not yet
    // available, so any source matching its destination must wait one cycle
    always_comb begin
        w_hazard = r_s1.vld & r_s1.wen & (r_s1.rd != '0)
                 & ((ID_RS1 == r_s1.rd) | (ID_RS2 == r_s1.rd));
        ID_READY = ~w_hazard;
        w_accept = ID_VALID & ~w_hazard;
        w_s2Fwd  = r_s2.vld & r_s2.wen & RD_WE;
        w_wbEn   = w_s2Fwd & (r_s2.rd != '0);
    end

    // Operand resolution: x0 first, then the in-flight ALU result, then array
    always_comb begin
        w_rs1Val = w_arr1;
        w_rs2Val = w_arr2;
        if (ID_RS1 == '0) begin
            w_rs1Val = '0;
        end else if (RD_WE && slot_targets(r_s2, ID_RS1)) begin
            w_rs1Val = RD_D;
        end
        if (ID_RS2 == '0) begin
            w_rs2Val = '0;
        end else if (RD_WE && slot_targets(r_s2, ID_RS2)) begin
            w_rs2Val = RD_D;
        end
    end

    // Pending-slot pipeline: S1 mirrors the op at the ALU, S2 the op retiring
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1.vld <= w_accept;
            r_s1.wen <= w_accept & ID_WEN;
            r_s1.rd  <= ID_RD;
            r_s2     <= r_s1;
        end
    end

    // Operand register toward the ALU; values hold while no op is accepted
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_rsValid <= 1'b0;
            r_rs1     <= '0;
            r_rs2     <= '0;
        end else begin
            r_rsValid <= w_accept;
            if (w_accept) begin
                r_rs1 <= w_rs1Val;
                r_rs2 <= w_rs2Val;
            end
        end
    end

    // Sticky protocol error: a result must arrive exactly when S2 is occupied
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_err <= 1'b0;
        end else if (RD_WE != r_s2.vld) begin
            r_err <= 1'b1;
        end
    end

    assign RS_D_VALID = r_rsValid;
    assign RS1_D      = r_rs1;
    assign RS2_D      = r_rs2;
    assign ERR        = r_err;

endmodule

// File: tb/tb_leve_operand_fetch.sv
// Directed bench for leve_operand_fetch. Issued ops push their expected
// operand pair into a queue; a monitor pops and compares on RS_D_VALID.
module tb_leve_operand_fetch;

    logic        CLK;
    logic        RSTn;
    logic        ID_VALID;
    logic        ID_READY;
    logic [4:0]  ID_RS1;
    logic [4:0]  ID_RS2;
    logic [4:0]  ID_RD;
    logic        ID_WEN;
    logic        RS_D_VALID;
    logic [31:0] RS1_D;
    logic [31:0] RS2_D;
    logic        RD_WE;
    logic [31:0] RD_D;
    logic [4:0]  DBG_RADDR;
    logic [31:0] DBG_RDATA;
    logic        ERR;

    int          numChecks = 0;
    int          numFails  = 0;
    logic [31:0] expQ1 [$];
    logic [31:0] expQ2 [$];
    logic [31:0] monE1;
    logic [31:0] monE2;

    leve_operand_fetch #(.XLEN(32)) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .ID_VALID   (ID_VALID),
        .ID_READY   (ID_READY),
        .ID_RS1     (ID_RS1),
        .ID_RS2     (ID_RS2),
        .ID_RD      (ID_RD),
        .ID_WEN     (ID_WEN),
        .RS_D_VALID (RS_D_VALID),
        .RS1_D      (RS1_D),
        .RS2_D      (RS2_D),
        .RD_WE      (RD_WE),
        .RD_D       (RD_D),
        .DBG_RADDR  (DBG_RADDR),
        .DBG_RDATA  (DBG_RDATA),
        .ERR        (ERR)
    );

    // Free-running clock, 10 time-unit period
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // One cycle of stimulus: inputs change just after the rising edge and
    // the task returns mid-cycle so combinational outputs can be checked
    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic wen,
                                 input logic rdwe, input logic [31:0] rdd);
        @(posedge CLK);
        #1;
        ID_VALID = v;
        ID_RS1   = rs1;
        ID_RS2   = rs2;
        ID_RD    = rd;
        ID_WEN   = wen;
        RD_WE    = rdwe;
        RD_D     = rdd;
        #2;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic expectOps(input logic [31:0] e1, input logic [31:0] e2);
        expQ1.push_back(e1);
        expQ2.push_back(e2);
    endtask

    task automatic checkDbg(input string name, input logic [4:0] idx, input logic [31:0] expected);
        DBG_RADDR = idx;
        #1;
        checkOutput(name, DBG_RDATA, expected);
    endtask

    // Monitor: every presented operand pair must match the oldest expectation
    always @(negedge CLK) begin
        if (RSTn && RS_D_VALID) begin
            if (expQ1.size() == 0) begin
                numChecks++;
                numFails++;
                $display("[TB] FAIL unexpected_op: got RS1_D=0x%08h RS2_D=0x%08h, expected no op",
                         RS1_D, RS2_D);
            end else begin
                monE1 = expQ1.pop_front();
                monE2 = expQ2.pop_front();
                checkOutput("RS1_D", RS1_D, monE1);
                checkOutput("RS2_D", RS2_D, monE2);
            end
        end
    end

    initial begin
        RSTn      = 1'b0;
        ID_VALID  = 1'b0;
        ID_RS1    = '0;
        ID_RS2    = '0;
        ID_RD     = '0;
        ID_WEN    = 1'b0;
        RD_WE     = 1'b0;
        RD_D      = '0;
        DBG_RADDR = '0;
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;
        #1;
        checkOutput("rst_ready", {31'b0, ID_READY}, 32'd1);
        checkOutput("rst_valid", {31'b0, RS_D_VALID}, 32'd0);
        checkOutput("rst_rs1", RS1_D, 32'h0);
        checkOutput("rst_err", {31'b0, ERR}, 32'd0);

        // Writeback through the array, read two idle cycles later
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 32'h0);
        expectOps(32'h0, 32'h0);
        idleCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0000_1234);
        idleCycle();
        idleCycle();
        applyStimulus(1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
        checkOutput("ready_nodep", {31'b0, ID_READY}, 32'd1);
        expectOps(32'h0000_1234, 32'h0);
        idleCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0);
        checkDbg("dbg_x3_a", 5'd3, 32'h0000_1234);

        // Back-to-back dependency: one bubble, then RD_D bypass
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 32'h0);
        expectOps(32'h0, 32'h0);
        applyStimulus(1'b1, 5'd3, 5'd3, 5'd5, 1'b1, 1'b0, 32'h0);
        checkOutput("ready_stall", {31'b0, ID_READY}, 32'd0);
        applyStimulus(1'b1, 5'd3, 5'd3, 5'd5, 1'b1, 1'b1, 32'hA5A5_0001);
        checkOutput("ready_after_bubble", {31'b0, ID_READY}, 32'd1);
        expectOps(32'hA5A5_0001, 32'hA5A5_0001);
        idleCycle();
        checkDbg("dbg_x3_b", 5'd3, 32'hA5A5_0001);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0000_0055);

        // Writes to x0 are dropped; x0 sources never stall nor take the bypass
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0);
        expectOps(32'h0, 32'h0);
        applyStimulus(1'b1, 5'd0, 5'd3, 5'd6, 1'b0, 1'b0, 32'h0);
        checkOutput("ready_x0", {31'b0, ID_READY}, 32'd1);
        expectOps(32'h0, 32'hA5A5_0001);
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        expectOps(32'h0, 32'h0);
        checkDbg("dbg_x0", 5'd0, 32'h0);
        checkDbg("dbg_x5", 5'd5, 32'h0000_0055);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0000_0077);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0000_0088);
        idleCycle();
        checkDbg("dbg_x6_nowen", 5'd6, 32'h0);

        // ID_WEN=0 result is discarded
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0, 32'h0);
        expectOps(32'h0, 32'h0);
        idleCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 32'hDEAD_0000);
        applyStimulus(1'b1, 5'd4, 5'd6, 5'd0, 1'b0, 1'b0, 32'h0);
        expectOps(32'h0, 32'h0);
        checkDbg("dbg_x4_nowen", 5'd4, 32'h0);
        idleCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0);

        // Full throughput with an S2 bypass on a same-cycle write and read
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0, 32'h0);
        expectOps(32'h0, 32'h0);
        applyStimulus(1'b1, 5'd3, 5'd5, 5'd8, 1'b1, 1'b0, 32'h0);
        checkOutput("ready_tp1", {31'b0, ID_READY}, 32'd1);
        expectOps(32'hA5A5_0001, 32'h0000_0055);
        applyStimulus(1'b1, 5'd7, 5'd0, 5'd9, 1'b1, 1'b1, 32'h0000_0700);
        checkOutput("ready_tp2", {31'b0, ID_READY}, 32'd1);
        expectOps(32'h0000_0700, 32'h0);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0000_0800);
        applyStimulus(1'b1, 5'd8, 5'd7, 5'd0, 1'b0, 1'b1, 32'h0000_0900);
        checkOutput("ready_tp3", {31'b0, ID_READY}, 32'd1);
        expectOps(32'h0000_0800, 32'h0000_0700);
        idleCycle();
        checkDbg("dbg_x9", 5'd9, 32'h0000_0900);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0);
        idleCycle();
        checkOutput("err_clean", {31'b0, ERR}, 32'd0);

        // Spurious RD_WE sets a sticky error
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0000_0001);
        idleCycle();
        checkOutput("err_spurious", {31'b0, ERR}, 32'd1);
        idleCycle();
        idleCycle();
        checkOutput("err_sticky", {31'b0, ERR}, 32'd1);

        // Reset mid-traffic, then a late RD_WE for the discarded op
        applyStimulus(1'b1, 5'd3, 5'd0, 5'd10, 1'b1, 1'b0, 32'h0);
        expectOps(32'hA5A5_0001, 32'h0);
        idleCycle();
        @(negedge CLK);
        #1;
        RSTn = 1'b0;
        #1;
        checkOutput("rst2_valid", {31'b0, RS_D_VALID}, 32'd0);
        checkOutput("rst2_rs1", RS1_D, 32'h0);
        checkOutput("rst2_rs2", RS2_D, 32'h0);
        checkOutput("rst2_err", {31'b0, ERR}, 32'd0);
        checkOutput("rst2_ready", {31'b0, ID_READY}, 32'd1);
        checkDbg("rst2_dbg_x5", 5'd5, 32'h0);
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 32'h0000_0123);
        idleCycle();
        checkOutput("err_late_we", {31'b0, ERR}, 32'd1);
        checkDbg("dbg_x10_discarded", 5'd10, 32'h0);

        // Missing RD_WE two cycles after accept
        @(negedge CLK);
        #1;
        RSTn = 1'b0;
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 32'h0);
        expectOps(32'h0, 32'h0);
        idleCycle();
        idleCycle();
        checkOutput("err_before_miss", {31'b0, ERR}, 32'd0);
        idleCycle();
        checkOutput("err_missing_we", {31'b0, ERR}, 32'd1);

        idleCycle();
        idleCycle();
        checkOutput("ops_outstanding", expQ1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/leve_operand_fetch.md
# leve_operand_fetch

Operand-fetch and register-file stage of the LEVE core; the upstream end of the ALU operand/writeback interface. It accepts decoded instructions over a valid/ready handshake and reads the integer register file. It drives registered operand pairs (RS_D_VALID/RS1_D/RS2_D) to the ALU. It retires the ALU's fixed-latency result (RD_WE/RD_D) into the destination register, tracking in-flight destinations so that dependent instructions stall or receive forwarded data.

## Interface
- XLEN, `XLEN (defs.vh), datapath width
- NREG, 32, architectural registers; x0 hardwired zero
- CLK  in  1  clock
- RSTn  in  1  reset, asynchronous, active-low
- ID_VALID  in  1  decoded instruction valid
- ID_READY  out  1  stage can accept this cycle (combinational)
- ID_RS1, ID_RS2  in  5  source register indices
- ID_RD  in  5  destination index
- ID_WEN  in  1  instruction writes ID_RD
- RS_D_VALID  out  1  operands valid to ALU (registered)
- RS1_D, RS2_D  out  XLEN  operand values (registered)
- RD_WE  in  1  ALU result valid
- RD_D  in  XLEN  ALU result
- DBG_RADDR  in  5  debug read index
- DBG_RDATA  out  XLEN  debug read data (combinational, array contents only, no forwarding)
- ERR  out  1  sticky writeback protocol error

## Operation
- Accept = ID_VALID & ID_READY. On accept: RS_D_VALID<=1 next cycle, RS1_D/RS2_D <= resolved operands; else RS_D_VALID<=0, RS1_D/RS2_D hold.
- Pending slots: S1 {vld,wen,rd} = instruction currently presented to ALU (mirrors RS_D_VALID); S2 = instruction whose result is on RD_WE/RD_D. Each cycle S1<=accept fields, S2<=S1.
- Writeback: S2.vld & S2.wen & RD_WE & S2.rd!=0 -> reg[S2.rd]<=RD_D. The ALU asserts RD_WE for every issued op; RD_D is discarded when S2.wen=0.
- Operand resolution per source, priority: index 0 -> 0; S2.vld & S2.wen & S2.rd==idx & RD_WE -> RD_D (bypass); else array.
- Stall: ID_READY=0 iff S1.vld & S1.wen & S1.rd!=0 & (ID_RS1==S1.rd | ID_RS2==S1.rd). Independent of ID_VALID. x0 sources never stall.
- ERR<=1 when RD_WE != S2.vld in any cycle. Cleared only by reset; the stage keeps running after an error.
- Writes to x0 are dropped; x0 always reads 0, including via DBG port.

## Timing
- Reset: RS_D_VALID=0, RS1_D=RS2_D=0, ERR=0, S1/S2 invalid, all registers 0. ID_READY=1 after reset.
- Latency: accept in cycle t -> RS_D_VALID in t+1 -> RD_WE expected in t+2 -> array updated at end of t+2, visible from array in t+3.
- Back-to-back dependency: one bubble (ID_READY low in t+1); the dependent op is accepted in t+2 using the RD_D bypass.
- Dependency on S2 only: no stall; bypass.
- Same-cycle write and read of the same index: the reader gets RD_D.
- Throughput: 1 op/cycle without dependencies.
- Reset mid-operation discards S1/S2 results. A late RD_WE after reset deassertion sets ERR.

## Structure
- leve_pkg: REG_AW=5, NREG, typedef reg_idx_t logic[4:0], struct pend_slot_t {vld,wen,rd}.
- Sub-module leve_regfile: NREG x XLEN storage with async reset, 2 combinational read ports plus debug port, 1 write port, x0 zero. Bypass, hazard and slot logic stay in leve_operand_fetch.

## Test plan
- Reset: RSTn low mid-traffic -> RS_D_VALID=0, RS1_D=RS2_D=0, ERR=0, ID_READY=1, DBG_RDATA(x5)=0.
- Issue rd=x3 (rs x0,x0), ALU returns RD_D=0x00001234. Two idle cycles later issue rs1=x3 -> RS1_D=0x00001234, no stall.
- I0 rd=x3, I1 rs1=x3,rs2=x3 presented next cycle -> ID_READY=0 one cycle, then RS1_D=RS2_D=0xA5A50001 via bypass.
- I0 rd=x0, RD_D=0xFFFFFFFF, then I1 rs1=x0 immediately -> no stall, RS1_D=0, DBG_RDATA(x0)=0.
- I0 rd=x4 ID_WEN=0, RD_D=0xDEAD0000 -> x4 unchanged (0).
- RD_WE pulse with no pending op -> ERR=1 and stays 1. A missing RD_WE two cycles after accept also sets ERR.
